operand_fetch: RTL

Requester for the register file's two read ports. Takes one decoded instruction carrying up to three source register addresses and drives the register file read enables and addresses. Collects the operands, with optional forwarding from the writeback port, and presents them to execute on a valid/ready handshake. Sits between decode and execute, alongside the register file.

---
 rtl/operand_fetch_pkg.sv | 17 +
 rtl/operand_fetch_if.sv | 56 +++++
 rtl/operand_fetch_bypass.sv | 30 +++
 rtl/operand_fetch.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand fetch block: FSM state encoding and default widths
// (the default widths match the register file).
package operand_fetch_pkg;

    localparam int OF_DATA_WIDTH    = 32;
    localparam int OF_LOG2_NUM_REGS = 4;
    localparam int OF_TAG_WIDTH     = 8;
    localparam int OF_NUM_SRCS      = 3;

    typedef enum logic [1:0] {
        OF_IDLE  = 2'd0,
        OF_RD_AB = 2'd1,
        OF_RD_C  = 2'd2,
        OF_OUT   = 2'd3
    } of_state_e;

endpackage

// File: rtl/operand_fetch_if.sv
// Bundle of the decode request, register file read, writeback snoop and execute channels.
// The master modport is the operand fetch side; the slave modport is its environment.
interface operand_fetch_if
    import operand_fetch_pkg::*;
#(
    parameter int DATA_WIDTH    = OF_DATA_WIDTH,
    parameter int LOG2_NUM_REGS = OF_LOG2_NUM_REGS,
    parameter int TAG_WIDTH     = OF_TAG_WIDTH
);

    logic                     req_valid;
    logic                     req_ready;
    logic [TAG_WIDTH-1:0]     req_tag;
    logic [OF_NUM_SRCS-1:0]   req_src_en;
    logic [LOG2_NUM_REGS-1:0] req_src_a;
    logic [LOG2_NUM_REGS-1:0] req_src_b;
    logic [LOG2_NUM_REGS-1:0] req_src_c;

    logic [1:0]               rf_read_en;
    logic [LOG2_NUM_REGS-1:0] rf_raddr_0;
    logic [LOG2_NUM_REGS-1:0] rf_raddr_1;
    logic [DATA_WIDTH-1:0]    rf_rdata_0;
    logic [DATA_WIDTH-1:0]    rf_rdata_1;

    logic                     wb_en;
    logic [LOG2_NUM_REGS-1:0] wb_addr;
    logic [DATA_WIDTH-1:0]    wb_data;

    logic                     op_valid;
    logic                     op_ready;
    logic [TAG_WIDTH-1:0]     op_tag;
    logic [DATA_WIDTH-1:0]    op_a;
    logic [DATA_WIDTH-1:0]    op_b;
    logic [DATA_WIDTH-1:0]    op_c;

    modport master (
        input  req_valid, req_tag, req_src_en, req_src_a, req_src_b, req_src_c,
        input  rf_rdata_0, rf_rdata_1,
        input  wb_en, wb_addr, wb_data,
        input  op_ready,
        output req_ready,
        output rf_read_en, rf_raddr_0, rf_raddr_1,
        output op_valid, op_tag, op_a, op_b, op_c
    );

    modport slave (
        output req_valid, req_tag, req_src_en, req_src_a, req_src_b, req_src_c,
        output rf_rdata_0, rf_rdata_1,
        output wb_en, wb_addr, wb_data,
        output op_ready,
        input  req_ready,
        input  rf_read_en, rf_raddr_0, rf_raddr_1,
        input  op_valid, op_tag, op_a, op_b, op_c
    );

endinterface

// File: rtl/operand_fetch_bypass.sv
// Per-read-port operand select: register file data, or writeback data on a same-cycle hit.
// Forwarding is compiled in only when WB_BYPASS_EN is defined.
module operand_bypass #(
    parameter int DATA_WIDTH    = 32,
    parameter int LOG2_NUM_REGS = 4
) (
    input  logic                     en,
    input  logic [LOG2_NUM_REGS-1:0] raddr,
    input  logic [DATA_WIDTH-1:0]    rdata,
    input  logic                     wb_en,
    input  logic [LOG2_NUM_REGS-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0]    wb_data,
    output logic [DATA_WIDTH-1:0]    value
);

`ifdef WB_BYPASS_EN
    // The register file writes on the edge, so a same-cycle write is not yet visible on rdata.
    always_comb begin
        value = '0;
        if (en) begin
            value = (wb_en && (wb_addr == raddr)) ? wb_data : rdata;
        end
    end
`else
    logic unused_wb;
    assign unused_wb = ^{wb_en, wb_addr, wb_data};
    assign value     = en ? rdata : '0;
`endif

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: reads up to three sources over two register file ports and hands them to execute.
// Optional writeback forwarding is enabled with the WB_BYPASS_EN macro.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int DATA_WIDTH    = OF_DATA_WIDTH,
    parameter int LOG2_NUM_REGS = OF_LOG2_NUM_REGS,
    parameter int TAG_WIDTH     = OF_TAG_WIDTH
) (
    input logic            clk,
    input logic            reset,
    operand_fetch_if.master bus
);

    of_state_e                state_q, state_d;
    logic [TAG_WIDTH-1:0]     tag_q, tag_d;
    logic [OF_NUM_SRCS-1:0]   src_en_q, src_en_d;
    logic [LOG2_NUM_REGS-1:0] src_a_q, src_a_d;
    logic [LOG2_NUM_REGS-1:0] src_b_q, src_b_d;
    logic [LOG2_NUM_REGS-1:0] src_c_q, src_c_d;
    logic [DATA_WIDTH-1:0]    op_a_q, op_a_d;
    logic [DATA_WIDTH-1:0]    op_b_q, op_b_d;
    logic [DATA_WIDTH-1:0]    op_c_q, op_c_d;

    logic                     rd_en_0, rd_en_1;
    logic [LOG2_NUM_REGS-1:0] rd_addr_0, rd_addr_1;
    logic [DATA_WIDTH-1:0]    sel_0, sel_1;
    logic                     req_ready;
    logic                     load;

    operand_bypass #(.DATA_WIDTH(DATA_WIDTH), .LOG2_NUM_REGS(LOG2_NUM_REGS)) u_bypass_0 (
        .en      (rd_en_0),
        .raddr   (rd_addr_0),
        .rdata   (bus.rf_rdata_0),
        .wb_en   (bus.wb_en),
        .wb_addr (bus.wb_addr),
        .wb_data (bus.wb_data),
        .value   (sel_0)
    );

    operand_bypass #(.DATA_WIDTH(DATA_WIDTH), .LOG2_NUM_REGS(LOG2_NUM_REGS)) u_bypass_1 (
        .en      (rd_en_1),
        .raddr   (rd_addr_1),
        .rdata   (bus.rf_rdata_1),
        .wb_en   (bus.wb_en),
        .wb_addr (bus.wb_addr),
        .wb_data (bus.wb_data),
        .value   (sel_1)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
        state_d   = state_q;
        tag_d     = tag_q;
        src_en_d  = src_en_q;
        src_a_d   = src_a_q;
        src_b_d   = src_b_q;
        src_c_d   = src_c_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        op_c_d    = op_c_q;
        rd_en_0   = 1'b0;
        rd_en_1   = 1'b0;
        rd_addr_0 = '0;
        rd_addr_1 = '0;
        req_ready = 1'b0;

        case (state_q)
            OF_IDLE: begin
                req_ready = !reset;
                if (bus.req_valid) state_d = OF_RD_AB;
            end
            OF_RD_AB: begin
                rd_en_0   = src_en_q[0];
                rd_en_1   = src_en_q[1];
                rd_addr_0 = src_en_q[0] ? src_a_q : '0;
                rd_addr_1 = src_en_q[1] ? src_b_q : '0;
                op_a_d    = sel_0;
                op_b_d    = sel_1;
                op_c_d    = '0;
                state_d   = src_en_q[2] ? OF_RD_C : OF_OUT;
            end
            OF_RD_C: begin
                rd_en_0   = src_en_q[2];
                rd_addr_0 = src_en_q[2] ? src_c_q : '0;
                op_c_d    = sel_0;
                state_d   = OF_OUT;
            end
            OF_OUT: begin
                req_ready = bus.op_ready && !reset;
                if (bus.op_ready) state_d = bus.req_valid ? OF_RD_AB : OF_IDLE;
            end
            default: state_d = OF_IDLE;
        endcase

        // A request is captured from IDLE, or from OUT in the same cycle as the execute handshake.
        load = bus.req_valid && req_ready;
        if (load) begin
            tag_d    = bus.req_tag;
            src_en_d = bus.req_src_en;
            src_a_d  = bus.req_src_a;
            src_b_d  = bus.req_src_b;
            src_c_d  = bus.req_src_c;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
        if (reset) begin
            state_q  <= OF_IDLE;
            tag_q    <= '0;
            src_en_q <= '0;
            src_a_q  <= '0;
            src_b_q  <= '0;
            src_c_q  <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_c_q   <= '0;
        end else begin
            state_q  <= state_d;
            tag_q    <= tag_d;
            src_en_q <= src_en_d;
            src_a_q  <= src_a_d;
            src_b_q  <= src_b_d;
            src_c_q  <= src_c_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            op_c_q   <= op_c_d;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.rf_read_en = {rd_en_1, rd_en_0};
    assign bus.rf_raddr_0 = rd_addr_0;
    assign bus.rf_raddr_1 = rd_addr_1;
    assign bus.op_valid   = (state_q == OF_OUT);
    assign bus.op_tag     = tag_q;
    assign bus.op_a       = op_a_q;
    assign bus.op_b       = op_b_q;
    assign bus.op_c       = op_c_q;

endmodule
